idli_fetch_m: RTL
=================

// Module: idli_fetch_m
// PURPOSE
// - Instruction fetch front end: the producer side of the 4b-per-cycle encoding stream consumed by decode.
// - Issues word reads to instruction memory and buffers the returned 16b words.
// - Serialises each word into four 4b slices aligned to the core slice counter.
// - Flushes and restarts fetch on a decode/execute redirect.
// PARAMETERS
// - DEPTH     2        number of 16b words held in the prefetch buffer; also the cap on buffered plus in-flight words.
// - RESET_PC  16'h0000 word address of the first fetch after reset.
// PORTS
// - i_fe_gck           in   1   clock; single clock domain.
// - i_fe_rst           in   1   reset; asynchronous, active-high.
// - i_fe_ctr           in   2   core slice counter; 0..3, wraps every cycle.
// - i_fe_hold          in   1   decode is not consuming the current word (LD/ST/POST_MEM); sampled at ctr==3.
// - i_fe_redirect      in   1   flush and refetch; legal only at ctr==3.
// - i_fe_redirect_pc   in   16  new word address; valid with i_fe_redirect.
// - o_fe_mem_vld       out  1   read request valid.
// - o_fe_mem_addr      out  16  read word address.
// - i_fe_mem_rdy       in   1   memory accepts request (vld&&rdy = accepted).
// - i_fe_mem_data_vld  in   1   read response valid; responses in request order; no backpressure.
// - i_fe_mem_data      in   16  read response word.
// - o_fe_enc           out  4   encoding slice to decode.
// - o_fe_enc_vld       out  1   slice valid.
// BEHAVIOUR
// - Reset (async, immediate):
//   - fetch PC = RESET_PC; buffer empty; outstanding = 0; drop count = 0.
//   - o_fe_mem_vld = 0, o_fe_enc_vld = 0, o_fe_enc = 0.
// - Request issue:
//   - o_fe_mem_vld = (occ_q + out_q < DEPTH) && !i_fe_redirect; uses registered counts only.
//   - o_fe_mem_addr = fetch PC.
//   - On accept: PC += 1 (16b wrap, 16'hFFFF -> 0); out += 1.
//   - While rdy is low, vld and addr hold stable.
//   - Counters are clog2(DEPTH+1) bits wide.
// - Response:
//   - Every data_vld decrements out.
//   - If drop_q != 0, drop -= 1 and the word is discarded; otherwise it is pushed to the buffer tail.
//   - A pushed word is readable from the next cycle.
// - Slice output:
//   - A presentation window is ctr 0..3. The window is valid iff the buffer is non-empty at the ctr==0 cycle.
//   - o_fe_enc_vld stays constant for the whole window; a word arriving mid-window waits for the next window.
//   - o_fe_enc = head[4*ctr+3 : 4*ctr] (combinational mux from registered head); 0 when not valid.
//   - Pop at ctr==3 iff vld && !i_fe_hold && !i_fe_redirect. When hold is high the same word is re-presented.
//   - Push and pop in the same cycle leave occupancy unchanged.
// - Redirect (at ctr==3):
//   - Buffer is emptied next cycle; PC = i_fe_redirect_pc.
//   - o_fe_mem_vld is forced low that cycle.
//   - drop = out_q - i_fe_mem_data_vld; a response in the redirect cycle is discarded itself.
//   - The following window is therefore invalid; first new request goes out the cycle after redirect.
//   - Redirect overrides hold.
// - Illegal cases (assertions, behaviour undefined):
//   - redirect with ctr != 3;
//   - data_vld with out_q == 0;
//   - push into a full buffer.
// TESTING
// - Reset, rdy=1, mem returns 16'hA5C3 for addr 0 -> window slices 3,C,5,A with vld=1; next request addr 1.
// - Buffer empty at ctr==0, response lands at ctr==1 -> vld=0 for that window; word presented in the following window.
// - hold=1 at ctr==3 on word 16'h1234 -> 4,3,2,1 repeated next window; hold=0 -> advances to next word.
// - Two requests outstanding, redirect to 16'h0040 -> both responses dropped; next o_fe_mem_addr=16'h0040; first valid window carries mem[0x40].
// - rdy=0 for 5 cycles -> addr stable, one accept only; buffer full (DEPTH words) -> o_fe_mem_vld=0 until a pop.
// - Reset asserted mid-window with out=1 -> outputs 0 immediately; after release first request addr=RESET_PC; stale response absent.

Source files
------------

// File: rtl/idli_fetch_m.sv
// idli_fetch_m - instruction fetch front end.
//
// Issues word reads to instruction memory, keeps up to DEPTH returned 16b
// words in a small prefetch buffer, and serialises the head word into four
// 4b slices (least significant first) aligned to the core slice counter.
// A redirect at the last slice flushes the buffer, discards every response
// still in flight and restarts fetch from the new word address.
//
// Ports
//   i_fe_gck          clock
//   i_fe_rst          asynchronous active-high reset
//   i_fe_ctr          core slice counter, 0..3
//   i_fe_hold         decode keeps the current word (sampled at ctr==3)
//   i_fe_redirect     flush and refetch (only at ctr==3)
//   i_fe_redirect_pc  new word address, valid with i_fe_redirect
//   o_fe_mem_vld      read request valid
//   o_fe_mem_addr     read word address
//   i_fe_mem_rdy      memory accepts the request
//   i_fe_mem_data_vld read response valid (in order, no backpressure)
//   i_fe_mem_data     read response word
//   o_fe_enc          encoding slice to decode
//   o_fe_enc_vld      slice valid (constant across a window)

module idli_fetch_m #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_fe_gck,
  input  logic        i_fe_rst,
  input  logic [1:0]  i_fe_ctr,
  input  logic        i_fe_hold,
  input  logic        i_fe_redirect,
  input  logic [15:0] i_fe_redirect_pc,
  output logic        o_fe_mem_vld,
  output logic [15:0] o_fe_mem_addr,
  input  logic        i_fe_mem_rdy,
  input  logic        i_fe_mem_data_vld,
  input  logic [15:0] i_fe_mem_data,
  output logic [3:0]  o_fe_enc,
  output logic        o_fe_enc_vld
);

  localparam int unsigned   CW       = $clog2(DEPTH + 1);
  localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  // Select slice idx (0 = least significant nibble) of a word.
  function automatic logic [3:0] slice_f(input logic [15:0] w, input logic [1:0] idx);
    return w[{idx, 2'b00} +: 4];
  endfunction

  // Advance a buffer pointer with wrap at DEPTH entries.
  function automatic logic [PW-1:0] ptr_inc_f(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1'b1);
  endfunction

  logic [15:0]   pc_r;
  logic [CW-1:0] occ_r;
  logic [CW-1:0] out_r;
  logic [CW-1:0] drop_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic          win_vld_r;
  logic [15:0]   buf_r [DEPTH];

  logic [CW:0]   level_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic          drop_hit_s;

  assign o_fe_mem_addr = pc_r;

  // Request valid, window valid, slice mux and buffer control strobes.
  always_comb begin
    level_s = {1'b0, occ_r} + {1'b0, out_r};
    if (i_fe_rst || i_fe_redirect) begin
      o_fe_mem_vld = 1'b0;
    end else begin
      o_fe_mem_vld = (level_s < {1'b0, DEPTH_C});
    end

    // The window decision is taken from the registered occupancy at ctr==0
    // and then held, so a word landing mid-window waits for the next one.
    if (i_fe_ctr == 2'd0) begin
      o_fe_enc_vld = (occ_r != {CW{1'b0}});
    end else begin
      o_fe_enc_vld = win_vld_r;
    end

    if (o_fe_enc_vld) begin
      o_fe_enc = slice_f(buf_r[rd_ptr_r], i_fe_ctr);
    end else begin
      o_fe_enc = 4'h0;
    end

    accept_s   = o_fe_mem_vld && i_fe_mem_rdy;
    drop_hit_s = i_fe_mem_data_vld && (drop_r != {CW{1'b0}});
    // A response arriving in the redirect cycle is stale as well.
    push_s     = i_fe_mem_data_vld && (drop_r == {CW{1'b0}}) && !i_fe_redirect;
    pop_s      = (i_fe_ctr == 2'd3) && o_fe_enc_vld && !i_fe_hold && !i_fe_redirect;
  end

  // Fetch PC, occupancy, outstanding/drop counters, pointers, window flag.
  always_ff @(posedge i_fe_gck or posedge i_fe_rst) begin
    if (i_fe_rst) begin
      pc_r      <= RESET_PC;
      occ_r     <= {CW{1'b0}};
      out_r     <= {CW{1'b0}};
      drop_r    <= {CW{1'b0}};
      rd_ptr_r  <= {PW{1'b0}};
      wr_ptr_r  <= {PW{1'b0}};
      win_vld_r <= 1'b0;
    end else begin
      out_r <= out_r + CW'(accept_s) - CW'(i_fe_mem_data_vld);
      if (i_fe_redirect) begin
        // Everything still outstanding after this cycle belongs to the old stream.
        pc_r     <= i_fe_redirect_pc;
        occ_r    <= {CW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
        wr_ptr_r <= {PW{1'b0}};
        drop_r   <= out_r - CW'(i_fe_mem_data_vld);
      end else begin
        if (accept_s) begin
          pc_r <= pc_r + 16'd1;
        end
        occ_r <= occ_r + CW'(push_s) - CW'(pop_s);
        if (push_s) begin
          wr_ptr_r <= ptr_inc_f(wr_ptr_r);
        end
        if (pop_s) begin
          rd_ptr_r <= ptr_inc_f(rd_ptr_r);
        end
        if (drop_hit_s) begin
          drop_r <= drop_r - CW'(1'b1);
        end
      end
      if (i_fe_ctr == 2'd0) begin
        win_vld_r <= (occ_r != {CW{1'b0}});
      end
    end
  end

  // Word storage; contents are only observed through a valid window.
  always_ff @(posedge i_fe_gck) begin
    if (push_s) begin
      buf_r[wr_ptr_r] <= i_fe_mem_data;
    end
  end

  idli_fetch_chk_m #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk      (i_fe_gck),
    .rst      (i_fe_rst),
    .ctr      (i_fe_ctr),
    .redirect (i_fe_redirect),
    .data_vld (i_fe_mem_data_vld),
    .out_cnt  (out_r),
    .occ_cnt  (occ_r),
    .push     (push_s)
  );

endmodule

// idli_fetch_chk_m - protocol checks for idli_fetch_m (no logic).
//   clk/rst   clock and active-high reset
//   ctr       slice counter; redirect/data_vld as seen by the fetch unit
//   out_cnt   outstanding requests; occ_cnt buffer occupancy; push buffer write
module idli_fetch_chk_m #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = 2
) (
  input logic          clk,
  input logic          rst,
  input logic [1:0]    ctr,
  input logic          redirect,
  input logic          data_vld,
  input logic [CW-1:0] out_cnt,
  input logic [CW-1:0] occ_cnt,
  input logic          push
);

  a_redirect_ctr: assert property (@(posedge clk) disable iff (rst)
    redirect |-> (ctr == 2'd3));

  a_rsp_has_req: assert property (@(posedge clk) disable iff (rst)
    data_vld |-> (out_cnt != {CW{1'b0}}));

  a_push_space: assert property (@(posedge clk) disable iff (rst)
    push |-> (occ_cnt < CW'(DEPTH)));

endmodule
